// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the fetch/data RAM arbiter: response owner encoding,
// default bus widths and the base address of the instruction/data RAM.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    localparam int          ADDR_W_DEFAULT = 32;
    localparam int          DATA_W_DEFAULT = 32;
    localparam logic [31:0] RAM_BASE       = 32'h1c00_0000;

endpackage

// File: rtl/ram_arb_fairness.sv
// Priority decision between fetch and data: data wins by default, but fetch is
// forced through after MAX_DATA_STREAK consecutive data wins while it waited.
module ram_arb_fairness #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_elig,
    input  logic d_req,
    output logic gnt_if,
    output logic gnt_d
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                fetch_due;

    assign fetch_due = if_elig && (streak == STREAK_MAX);
    assign gnt_d     = d_req && !fetch_due;
    assign gnt_if    = if_elig && !gnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (gnt_if || !if_elig) begin
            streak <= '0;
        end else if (gnt_d && streak != STREAK_MAX) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: one access per cycle, owner-tagged one-cycle read
// responses, fetch starvation bound and branch-flush discard of fetch data.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              ram_ce_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wen_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    logic   if_elig;
    logic   d_req_live;
    logic   gnt_if;
    logic   gnt_d;
    logic   d_read;
    owner_e resp_owner;

    // Requests are masked while reset is held so nothing reaches the RAM.
    assign if_elig    = if_req_i && !flush_i && !reset;
    assign d_req_live = d_req_i && !reset;

    ram_arb_fairness #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_W        (STREAK_W)
    ) u_fairness (
        .clock   (clock),
        .reset   (reset),
        .if_elig (if_elig),
        .d_req   (d_req_live),
        .gnt_if  (gnt_if),
        .gnt_d   (gnt_d)
    );

    assign d_read    = gnt_d && !d_we_i;
    assign if_gnt_o  = gnt_if;
    assign d_gnt_o   = gnt_d;
    assign ram_ce_o  = gnt_if || gnt_d;
    assign ram_wen_o = gnt_d && d_we_i;

    // NOTE: every output gets a default first so no path through this block
    // can infer a latch.
    always_comb begin
        ram_raddr_o = '0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        if (gnt_if) begin
            ram_raddr_o = if_addr_i;
        end else if (d_read) begin
            ram_raddr_o = d_addr_i;
        end
        if (ram_wen_o) begin
            ram_waddr_o = d_addr_i;
            ram_wdata_o = d_wdata_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_owner <= OWNER_NONE;
        end else if (gnt_if) begin
            resp_owner <= OWNER_IF;
        end else if (d_read) begin
            resp_owner <= OWNER_DATA;
        end else begin
            resp_owner <= OWNER_NONE;
        end
    end

    // A fetch grant implies no flush at issue, so only a flush now can kill it.
    assign if_rvalid_o = (resp_owner == OWNER_IF) && !flush_i;
    assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : '0;
    assign d_rvalid_o  = (resp_owner == OWNER_DATA);
    assign d_rdata_o   = d_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int MAX_STREAK = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0;
    logic [31:0] d_wdata_i = '0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        ram_ce_o, ram_wen_o;
    logic [31:0] ram_raddr_o, ram_waddr_o, ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    ram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAX_STREAK), .STREAK_W(3)
    ) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .ram_ce_o(ram_ce_o), .ram_raddr_o(ram_raddr_o),
        .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o),
        .ram_wen_o(ram_wen_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    // Environment RAM: driven purely by the DUT's RAM port.
    logic [31:0] ram_mem [logic [31:0]];
    always @(posedge clock) begin
        if (ram_ce_o && ram_wen_o) begin
            ram_mem[ram_waddr_o] = ram_wdata_o;
            ram_rdata_i <= $urandom();
        end else if (ram_ce_o) begin
            ram_rdata_i <= ram_mem.exists(ram_raddr_o) ? ram_mem[ram_raddr_o]
                                                       : init_word(ram_raddr_o);
        end else begin
            ram_rdata_i <= $urandom();
        end
    end

    // Reference model state.
    logic [31:0] shadow [logic [31:0]];
    int          m_waits = 0;
    int          m_owner = 0;
    logic [31:0] m_rdata = '0;
    logic        m_last_gf = 1'b0;
    logic        m_last_gd = 1'b0;

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waits   = 0;
        m_owner   = 0;
        m_last_gf = 1'b0;
        m_last_gd = 1'b0;
    endtask

    // Called with inputs settled, away from the clock edge.
    task automatic eval_cycle();
        logic elig, gf, gd, exp_ifv, exp_dv;
        elig = if_req_i && !flush_i;
        if (elig && d_req_i) begin
            gf = (m_waits >= MAX_STREAK);
            gd = !gf;
        end else begin
            gf = elig;
            gd = d_req_i;
        end
        check("if_gnt", 32'(if_gnt_o), 32'(gf));
        check("d_gnt", 32'(d_gnt_o), 32'(gd));
        check("ram_ce", 32'(ram_ce_o), 32'(gf || gd));
        check("ram_wen", 32'(ram_wen_o), 32'(gd && d_we_i));
        if (gf) check("raddr_if", ram_raddr_o, if_addr_i);
        else if (gd && !d_we_i) check("raddr_d", ram_raddr_o, d_addr_i);
        if (gd && d_we_i) begin
            check("waddr", ram_waddr_o, d_addr_i);
            check("wdata", ram_wdata_o, d_wdata_i);
        end
        exp_ifv = (m_owner == 1) && !flush_i;
        exp_dv  = (m_owner == 2);
        check("if_rvalid", 32'(if_rvalid_o), 32'(exp_ifv));
        check("if_rdata", if_rdata_o, exp_ifv ? m_rdata : 32'h0);
        check("d_rvalid", 32'(d_rvalid_o), 32'(exp_dv));
        check("d_rdata", d_rdata_o, exp_dv ? m_rdata : 32'h0);

        if (gf) begin
            m_owner = 1;
            m_rdata = shadow_rd(if_addr_i);
        end else if (gd && !d_we_i) begin
            m_owner = 2;
            m_rdata = shadow_rd(d_addr_i);
        end else begin
            m_owner = 0;
        end
        if (gd && d_we_i) shadow[d_addr_i] = d_wdata_i;
        // Count of consecutive cycles fetch sat eligible but lost to data.
        if (elig && !gf) m_waits = (m_waits < MAX_STREAK) ? m_waits + 1 : MAX_STREAK;
        else m_waits = 0;
        m_last_gf = gf;
        m_last_gd = gd;
    endtask

    task automatic step();
        #1;
        eval_cycle();
    endtask

    task automatic idle_inputs();
        if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; flush_i = 1'b0;
    endtask

    string pat;

    initial begin
        // Reset state.
        @(negedge clock);
        #1;
        check("rst_if_gnt", 32'(if_gnt_o), 0);
        check("rst_ram_ce", 32'(ram_ce_o), 0);
        check("rst_if_rvalid", 32'(if_rvalid_o), 0);
        check("rst_d_rvalid", 32'(d_rvalid_o), 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // Back-to-back fetches.
        if_req_i = 1'b1; if_addr_i = RAM_BASE;
        step();
        check("f0_gnt", 32'(if_gnt_o), 1);
        @(negedge clock);
        if_addr_i = RAM_BASE + 32'h4;
        step();
        check("f1_gnt", 32'(if_gnt_o), 1);
        check("f0_rvalid", 32'(if_rvalid_o), 1);
        check("f0_rdata", if_rdata_o, 32'h465a_0000);
        @(negedge clock);
        idle_inputs();
        step();
        check("f1_rvalid", 32'(if_rvalid_o), 1);
        check("f1_rdata", if_rdata_o, 32'h465a_0004);
        @(negedge clock);

        // Write then read back.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h1c00_0100; d_wdata_i = 32'hdead_beef;
        step();
        check("wr_wen", 32'(ram_wen_o), 1);
        @(negedge clock);
        d_we_i = 1'b0;
        step();
        check("wr_no_rvalid", 32'(d_rvalid_o), 0);
        @(negedge clock);
        idle_inputs();
        step();
        check("rd_rvalid", 32'(d_rvalid_o), 1);
        check("rd_rdata", d_rdata_o, 32'hdead_beef);
        @(negedge clock);

        // Continuous contention: data streak bounded by MAX_STREAK.
        pat = "";
        if_req_i = 1'b1; if_addr_i = RAM_BASE + 32'h8;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = RAM_BASE + 32'h40;
        for (int i = 0; i < 10; i++) begin
            step();
            pat = {pat, if_gnt_o ? "F" : (d_gnt_o ? "D" : "-")};
            @(negedge clock);
        end
        n_vec++;
        if (pat != "DDDDFDDDDF") begin
            n_miss++;
            $display("FAIL grant_pattern: got %s expected DDDDFDDDDF", pat);
        end
        idle_inputs();
        step();
        @(negedge clock);

        // Flush kills the in-flight fetch response and a same-cycle fetch request.
        if_req_i = 1'b1; if_addr_i = RAM_BASE + 32'hc;
        step();
        @(negedge clock);
        flush_i = 1'b1; if_addr_i = RAM_BASE + 32'h10;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = RAM_BASE + 32'h20;
        step();
        check("flush_rvalid", 32'(if_rvalid_o), 0);
        check("flush_if_gnt", 32'(if_gnt_o), 0);
        check("flush_d_gnt", 32'(d_gnt_o), 1);
        @(negedge clock);
        idle_inputs();
        step();
        check("flush_d_rdata", d_rdata_o, 32'h465a_0020);
        @(negedge clock);

        // Asynchronous reset with a data read in flight.
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = RAM_BASE + 32'h24;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_d_gnt", 32'(d_gnt_o), 0);
        check("arst_ram_ce", 32'(ram_ce_o), 0);
        check("arst_d_rvalid", 32'(d_rvalid_o), 0);
        model_reset();
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        step();
        check("arst_no_rvalid", 32'(d_rvalid_o), 0);
        @(negedge clock);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!(if_req_i && !flush_i && !m_last_gf)) begin
                if_req_i  = ($urandom_range(0, 9) < 7);
                if_addr_i = RAM_BASE + 32'($urandom_range(0, 15)) * 4;
            end
            if (!(d_req_i && !m_last_gd)) begin
                d_req_i   = ($urandom_range(0, 9) < 6);
                d_we_i    = ($urandom_range(0, 9) < 4);
                d_addr_i  = RAM_BASE + 32'($urandom_range(0, 15)) * 4;
                d_wdata_i = $urandom();
            end
            flush_i = ($urandom_range(0, 99) < 15);
            step();
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port synchronous instruction/data RAM between the fetch stage (read-only) and the memory stage (read/write). It issues at most one RAM access per cycle and tags each access with its owner. It returns each one-cycle-late read response to the correct requester. It bounds fetch starvation and discards fetch responses that a branch has invalidated.

Parameters:
ADDR_W, 32, width of all addresses
DATA_W, 32, width of read/write data
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is waiting; must be at least 1
STREAK_W, 3, counter width; must satisfy 2^STREAK_W > MAX_DATA_STREAK

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush_i  in  1  branch taken; kills fetch request this cycle and any fetch response in flight
if_req_i  in  1  fetch read request
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch data valid
if_rdata_o  out  DATA_W  fetch data
d_req_i  in  1  data request
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_gnt_o  out  1  data request accepted this cycle
d_rvalid_o  out  1  data read valid; never asserted for writes
d_rdata_o  out  DATA_W  data read result
ram_ce_o  out  1  RAM chip enable
ram_raddr_o  out  ADDR_W  RAM read address
ram_waddr_o  out  ADDR_W  RAM write address
ram_wdata_o  out  DATA_W  RAM write data
ram_wen_o  out  1  RAM write enable
ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after the read is issued

Behaviour:
- Reset (async, active-high): resp_owner=NONE, streak=0. All *_gnt_o, *_rvalid_o, ram_ce_o and ram_wen_o are 0. Data outputs are 0.
- Grants are combinational, in the same cycle as the request. A requester must hold req and its fields stable until gnt.
- Arbitration each cycle:
  - Fetch is eligible when if_req_i=1 and flush_i=0.
  - Data only: grant data.
  - Fetch only: grant fetch.
  - Both eligible: grant data, unless streak==MAX_DATA_STREAK, in which case grant fetch.
  - Neither: ram_ce_o=0 and no grant.
- streak counter:
  - Increments on a data grant while fetch is eligible but not granted.
  - Clears on a fetch grant, or when fetch is not eligible.
  - Saturates at MAX_DATA_STREAK.
- Issue:
  - Any grant drives ram_ce_o=1.
  - Fetch grant: ram_raddr_o=if_addr_i, ram_wen_o=0.
  - Data read: ram_raddr_o=d_addr_i, ram_wen_o=0.
  - Data write: ram_waddr_o=d_addr_i, ram_wdata_o=d_wdata_i, ram_wen_o=1. A write completes at grant; there is no response.
- Response tracking: register resp_owner is loaded each cycle with IF (fetch grant), DATA (data read grant) or NONE (write or idle).
- Response, in the cycle after issue (latency exactly 1):
  - resp_owner==IF: if_rvalid_o=1 and if_rdata_o=ram_rdata_i, unless flush_i was asserted in the issue cycle or is asserted in the response cycle. Such a response is dropped.
  - resp_owner==DATA: d_rvalid_o=1 and d_rdata_o=ram_rdata_i. A data response is never flushed.
- Throughput: back-to-back issues every cycle are allowed. A response and a new issue can occur in the same cycle.
- flush_i and if_req_i together: if_gnt_o=0, and data may be granted that cycle.
- Reset mid-operation: an in-flight response is discarded; no rvalid pulse follows reset release.
- Unused rdata outputs hold 0 when rvalid is low.

Decomposition:
- Shared package holds:
  - owner encoding OWNER_NONE=2'd0, OWNER_IF=2'd1, OWNER_DATA=2'd2
  - ADDR_W/DATA_W defaults and the RAM base address constant
- One natural sub-module: ram_arb_fairness. It contains the streak counter and the priority decision, with inputs if_elig and d_req and outputs gnt_if and gnt_d.
- The top level handles RAM muxing, resp_owner and flush masking.

Test Plan:
- Fetch-only reads at 0x1c000000 and 0x1c000004 in consecutive cycles -> if_gnt_o=1 both cycles; if_rvalid_o=1 one cycle after each, carrying the RAM words for those addresses in order.
- Data write 0xDEADBEEF to 0x1c000100, then a data read of 0x1c000100 -> write grant with ram_wen_o=1 and no d_rvalid_o; read returns 0xDEADBEEF with d_rvalid_o=1 one cycle later.
- Fetch and data requesting continuously, MAX_DATA_STREAK=4 -> grant pattern D,D,D,D,F repeating; no fetch wait exceeds 4 cycles.
- Fetch granted in cycle N, flush_i=1 in cycle N+1 -> if_rvalid_o stays 0 in N+1. if_req_i with flush_i in cycle N+1 -> if_gnt_o=0.
- Data read granted, reset asserted asynchronously before the next clock edge -> outputs 0 immediately; no d_rvalid_o after release; resp_owner=NONE.
